// File: rtl/count_uart_tx.sv
// count_uart_tx: serialises 8-bit counter snapshots onto a UART TX line.
// A one-entry holding register sits between the valid/ready producer and the
// bit shifter, so the next byte can be queued while the current frame shifts
// and frames can run back-to-back with no idle gap.
// Optional build macro: COUNT_UART_PARITY_EN adds an even-parity bit after
// the data bits (8E1, 11 bit times per frame); without it framing is 8N1.
`timescale 1ns/1ps
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef COUNT_UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef COUNT_UART_PARITY_EN
  // Even parity over the payload: the line bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Registered state
  state_t            state_r;
  logic [DATA_W-1:0] hold_r;
  logic              hold_full_r;
  logic [DATA_W-1:0] shifter_r;
  logic [2:0]        bit_idx_r;
  logic [CNT_W-1:0]  baud_r;
  logic              tx_r;
  logic              busy_r;
  logic              in_ready_r;

  // Next-state values
  state_t            state_s;
  logic [DATA_W-1:0] hold_s;
  logic              hold_full_s;
  logic [DATA_W-1:0] shifter_s;
  logic [2:0]        bit_idx_s;
  logic [CNT_W-1:0]  baud_s;
  logic              tx_s;
  logic              busy_s;
  logic              in_ready_s;
  logic              load_s;
  logic              accept_s;
  logic              baud_wrap_s;

  // Next-state logic: frame sequencing, holding register and registered outputs.
  always_comb begin
    state_s     = state_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    shifter_s   = shifter_r;
    bit_idx_s   = bit_idx_r;
    baud_s      = baud_r;
    load_s      = 1'b0;
    tx_s        = 1'b1;
    accept_s    = in_valid & in_ready_r;
    baud_wrap_s = (baud_r == BAUD_LAST);

    case (state_r)
      IDLE: begin
        baud_s    = {CNT_W{1'b0}};
        bit_idx_s = 3'd0;
        if (hold_full_r) begin
          load_s  = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_wrap_s) begin
          baud_s    = {CNT_W{1'b0}};
          bit_idx_s = 3'd0;
          state_s   = DATA;
        end else begin
          baud_s = baud_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (baud_wrap_s) begin
          baud_s = {CNT_W{1'b0}};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
`ifdef COUNT_UART_PARITY_EN
            state_s   = PARITY;
`else
            state_s   = STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef COUNT_UART_PARITY_EN
      PARITY: begin
        if (baud_wrap_s) begin
          baud_s  = {CNT_W{1'b0}};
          state_s = STOP;
        end else begin
          baud_s = baud_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      STOP: begin
        if (baud_wrap_s) begin
          baud_s = {CNT_W{1'b0}};
          // A queued byte starts its frame straight after this stop bit.
          if (hold_full_r) begin
            load_s  = 1'b1;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s   = IDLE;
        baud_s    = {CNT_W{1'b0}};
        bit_idx_s = 3'd0;
      end
    endcase

    // Shifter reload and producer transfer may coincide; both take effect.
    if (load_s) begin
      shifter_s = hold_r;
    end else begin
      shifter_s = shifter_r;
    end

    if (accept_s) begin
      hold_s      = in_data;
      hold_full_s = 1'b1;
    end else if (load_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end

    // Line level follows the current state; it is registered, so it lags
    // the state by one clock and never glitches.
    case (state_r)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shifter_r[bit_idx_r];
`ifdef COUNT_UART_PARITY_EN
      PARITY:  tx_s = even_parity(shifter_r);
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s     = (state_s != IDLE) | hold_full_s;
    in_ready_s = ~hold_full_s;
  end

  // State register with synchronous reset; reset aborts any frame and drops the held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_r      <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
      shifter_r   <= {DATA_W{1'b0}};
      bit_idx_r   <= 3'd0;
      baud_r      <= {CNT_W{1'b0}};
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      shifter_r   <= shifter_s;
      bit_idx_r   <= bit_idx_s;
      baud_r      <= baud_s;
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign in_ready = in_ready_r;

endmodule
